aes_dec_arbiter: RTL and testbench

AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_dec_arbiter_if.sv | 30 +++
 rtl/aes_dec_arbiter_rr_arbiter2.sv | 16 +
 rtl/aes_dec_arbiter.sv | 156 +++++++++++++++
 tb/tb_aes_dec_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES decryption-core arbiter: block width,
// requester count and the FSM state encoding.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned NUM_REQ = 2;

    typedef logic [BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } aes_state_e;

endpackage

// File: rtl/aes_dec_arbiter_if.sv
// Requester, core and response signals shared between the arbiter (slave)
// and its environment (master).
interface aes_dec_arbiter_if import aes_pkg::*; ();

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    aes_block_t         req_data0;
    aes_block_t         req_data1;

    logic               core_start;
    aes_block_t         core_data;
    logic               core_done;
    aes_block_t         core_result;

    logic [NUM_REQ-1:0] resp_valid;
    logic [NUM_REQ-1:0] resp_ready;
    aes_block_t         resp_data;
    logic               resp_err;

    modport slave (
        input  req_valid, req_data0, req_data1, core_done, core_result, resp_ready,
        output req_ready, core_start, core_data, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_data0, req_data1, core_done, core_result, resp_ready,
        input  req_ready, core_start, core_data, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/aes_dec_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: the pointer breaks ties, a lone request wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant, preferred requester wins only on contention
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/aes_dec_arbiter.sv
// Arbitrates two requesters onto one AES decryption core, one block in
// flight at a time. Optional BUSY watchdog enabled by AES_DEC_ARB_TIMEOUT_EN.
module aes_dec_arbiter import aes_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    aes_dec_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE = 2'(ISSUE);
    localparam logic [1:0] ST_BUSY  = 2'(BUSY);
    localparam logic [1:0] ST_RESP  = 2'(RESP);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ptr;
    logic       gnt_q;
    logic [1:0] gnt_onehot;
    aes_block_t hold;
    aes_block_t result;
    logic       timeout_hit;
    logic       accept;
    logic       resp_done;

    rr_arbiter2 u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (gnt_onehot)
    );

    assign accept    = (state == ST_IDLE) && (|bus.req_valid);
    assign resp_done = (state == ST_RESP) && bus.resp_ready[gnt_q];

`ifdef AES_DEC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err;

    // Counts BUSY cycles, restarting each time a block is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // The current BUSY cycle is the last one allowed
    assign timeout_hit = (state == ST_BUSY) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Error flag for the pending response; a real completion always wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (state == ST_BUSY) begin
            if (bus.core_done) begin
                err <= 1'b0;
            end else if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.resp_err = err;
`else
    // TIMEOUT_CYCLES only shapes the watchdog build
    if (TIMEOUT_CYCLES == 0) begin : g_tmo_cfg_unused
    end

    assign timeout_hit  = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = '0;
        bus.core_start = 1'b0;
        bus.resp_valid = '0;
        case (state)
            ST_IDLE: begin
                if (!rst && accept) begin
                    bus.req_ready = gnt_onehot;
                    state_nxt     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.core_start = 1'b1;
                state_nxt      = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.core_done || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.resp_valid = gnt_q ? 2'b10 : 2'b01;
                if (bus.resp_ready[gnt_q]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the granted ciphertext and who owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold  <= '0;
            gnt_q <= 1'b0;
        end else if (accept) begin
            hold  <= gnt_onehot[1] ? bus.req_data1 : bus.req_data0;
            gnt_q <= gnt_onehot[1];
        end
    end

    // Capture the plaintext, or zero on a watchdog abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
        end else if (state == ST_BUSY) begin
            if (bus.core_done) begin
                result <= bus.core_result;
            end else if (timeout_hit) begin
                result <= '0;
            end
        end
    end

    // Pointer prefers the other requester once a response is handed over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (resp_done) begin
            ptr <= ~gnt_q;
        end
    end

    assign bus.core_data = hold;
    assign bus.resp_data = result;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// Directed bench for aes_dec_arbiter; the bench plays both requesters and the
// decryption core (plaintext = ciphertext ^ KEY) and scores responses.
module tb_aes_dec_arbiter;
    import aes_pkg::*;

    typedef struct {
        logic         idx;
        logic [127:0] data;
        logic         err;
    } exp_t;

    localparam logic [127:0] KEY  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] CT_A = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] CT_B = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] CT_C = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] CT_D = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] CT_E = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] CT_G = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    aes_dec_arbiter_if bus();

    aes_dec_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] onehot(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_req_ready"},  128'(bus.req_ready),  128'd0);
        check({tag, "_core_start"}, 128'(bus.core_start), 128'd0);
        check({tag, "_core_data"},  bus.core_data,        128'd0);
        check({tag, "_resp_valid"}, 128'(bus.resp_valid), 128'd0);
        check({tag, "_resp_data"},  bus.resp_data,        128'd0);
        check({tag, "_resp_err"},   128'(bus.resp_err),   128'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        bus.core_done  = 1'b1;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst");
        @(negedge clk);
        check_outputs_zero("rst_hold");
        rst = 1'b0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        bus.core_done  = 1'b0;
        @(negedge clk);
    endtask

    // Wait for a response, score it, optionally stall, then hand it over
    task automatic wait_resp(input int stall);
        int   waited;
        exp_t e;
        waited = 0;
        while (bus.resp_valid == 2'b00 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        check("resp_latency", 128'(waited), 128'd0);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("resp_valid", 128'(bus.resp_valid), 128'(onehot(e.idx)));
            check("resp_data",  bus.resp_data,        e.data);
            check("resp_err",   128'(bus.resp_err),   128'(e.err));
            for (int i = 0; i < stall; i++) begin
                bus.req_valid  = 2'b10;
                bus.resp_ready = onehot(~e.idx);
                #1;
                check("stall_req_ready", 128'(bus.req_ready), 128'd0);
                @(negedge clk);
                check("stall_resp_valid", 128'(bus.resp_valid), 128'(onehot(e.idx)));
                check("stall_resp_data",  bus.resp_data,        e.data);
            end
            bus.resp_ready = onehot(e.idx);
            @(negedge clk);
            bus.resp_ready = 2'b00;
            check("resp_release", 128'(bus.resp_valid), 128'd0);
        end
    endtask

    // One full transaction; called at a negedge with the DUT idle
    task automatic serve(input logic [1:0] valid_in, input logic exp_idx,
                         input logic [127:0] ct, input logic [127:0] pt,
                         input int dly, input bit use_done, input bit done_in_issue,
                         input int stall);
        exp_t e;
        bus.req_valid = valid_in;
        #1;
        check("accept_grant", 128'(bus.req_ready), 128'(onehot(exp_idx)));
        e.idx  = exp_idx;
        e.data = use_done ? pt : 128'd0;
        e.err  = !use_done;
        sb.push_back(e);
        @(negedge clk);
        check("issue_start",     128'(bus.core_start), 128'd1);
        check("issue_core_data", bus.core_data,        ct);
        check("issue_req_ready", 128'(bus.req_ready),  128'd0);
        if (done_in_issue) begin
            bus.core_done   = 1'b1;
            bus.core_result = ~pt;
        end
        @(negedge clk);
        bus.core_done = 1'b0;
        check("start_once", 128'(bus.core_start), 128'd0);
        for (int i = 0; i < dly; i++) begin
            check("busy_no_resp",   128'(bus.resp_valid), 128'd0);
            check("busy_core_data", bus.core_data,        ct);
            @(negedge clk);
        end
        if (use_done) begin
            bus.core_done   = 1'b1;
            bus.core_result = pt;
        end
        @(negedge clk);
        bus.core_done = 1'b0;
        wait_resp(stall);
    endtask

    initial begin
        bus.req_valid   = 2'b00;
        bus.req_data0   = '0;
        bus.req_data1   = '0;
        bus.resp_ready  = 2'b00;
        bus.core_done   = 1'b0;
        bus.core_result = '0;

        do_reset();

        // Known vector, done in cycle 5
        bus.req_data0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        serve(2'b01, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 3, 1'b1, 1'b0, 0);
        bus.req_valid = 2'b00;

        // Round-robin alternation with both requesters held, minimum latency first
        do_reset();
        bus.req_data0 = CT_A;
        bus.req_data1 = CT_B;
        serve(2'b11, 1'b0, CT_A, CT_A ^ KEY, 0, 1'b1, 1'b0, 0);
        serve(2'b11, 1'b1, CT_B, CT_B ^ KEY, 1, 1'b1, 1'b0, 0);
        serve(2'b11, 1'b0, CT_A, CT_A ^ KEY, 2, 1'b1, 1'b0, 0);
        bus.req_valid = 2'b00;

        // Lone request beats the pointer; response back-pressure; back-to-back grant
        bus.req_data0 = CT_C;
        bus.req_data1 = CT_D;
        serve(2'b01, 1'b0, CT_C, CT_C ^ KEY, 1, 1'b1, 1'b0, 10);
        serve(2'b10, 1'b1, CT_D, CT_D ^ KEY, 0, 1'b1, 1'b0, 0);
        bus.req_valid = 2'b00;

        // Stray core_done in IDLE and ISSUE is ignored
        bus.core_done   = 1'b1;
        bus.core_result = CT_E;
        @(negedge clk);
        bus.core_done = 1'b0;
        check("idle_done_resp",  128'(bus.resp_valid), 128'd0);
        check("idle_done_start", 128'(bus.core_start), 128'd0);
        bus.req_data0 = CT_E;
        serve(2'b01, 1'b0, CT_E, CT_E ^ KEY, 2, 1'b1, 1'b1, 0);
        bus.req_valid = 2'b00;

        // Reset while BUSY discards the request
        bus.req_data0 = CT_G;
        bus.req_valid = 2'b01;
        #1;
        check("abort_accept", 128'(bus.req_ready), 128'(2'b01));
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("abort_issue", 128'(bus.core_start), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        bus.core_done   = 1'b1;
        bus.core_result = CT_G ^ KEY;
        @(negedge clk);
        bus.core_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort_no_resp",    128'(bus.resp_valid), 128'd0);
            check("abort_no_restart", 128'(bus.core_start), 128'd0);
            @(negedge clk);
        end

        // Pointer back at requester 0 after reset
        serve(2'b11, 1'b0, CT_G, CT_G ^ KEY, 0, 1'b1, 1'b0, 0);
        bus.req_valid = 2'b00;

`ifdef AES_DEC_ARB_TIMEOUT_EN
        // Watchdog abort after four BUSY cycles, then done on the last cycle wins
        bus.req_data0 = CT_A;
        serve(2'b01, 1'b0, CT_A, CT_A ^ KEY, 3, 1'b0, 1'b0, 0);
        serve(2'b01, 1'b0, CT_A, CT_A ^ KEY, 3, 1'b1, 1'b0, 0);
        bus.req_valid = 2'b00;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
